// File: rtl/exec_wb.sv
// Execute/write-back stage: ALU write-back onto the shared RF bus, BRZ resolution,
// PRINT FIFO toward the console and END latch. Optional print pop counter: EXEC_PRINT_CNT_EN.
module exec_wb #(
    parameter int unsigned NCORES      = 4,
    parameter int unsigned PRINT_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [15:0]            ins_in,
    input  logic [15:0]            val_in,
    input  logic [15:0]            ptr_in,
    output logic                   exec_stall,
    input  logic [NCORES*35-1:0]   rf_in,
    output logic [NCORES*35-1:0]   rf_out,
    output logic                   branch_en,
    output logic [15:0]            branch_pc,
    output logic                   print_valid,
    output logic [7:0]             print_data,
    input  logic                   print_ready,
`ifdef EXEC_PRINT_CNT_EN
    output logic [15:0]            print_cnt,
`endif
    output logic                   core_done
);

    localparam int unsigned ENTRY_W = 35;
    localparam int unsigned PTR_W   = $clog2(PRINT_DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;

    localparam logic [3:0] OP_PLUS  = 4'h1;
    localparam logic [3:0] OP_MINUS = 4'h2;
    localparam logic [3:0] OP_BRZ   = 4'h5;
    localparam logic [3:0] OP_PRINT = 4'h9;
    localparam logic [3:0] OP_END   = 4'hA;

    logic [15:0]      ins_q, val_q, ptr_q;
    logic [3:0]       op;
    logic [15:0]      imm;
    logic [15:0]      res;
    logic             is_alu, is_print;
    logic             push, pop, full;
    logic [PTR_W-1:0] rd_q, wr_q;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       mem [PRINT_DEPTH];

    assign op       = ins_q[15:12];
    assign imm      = {4'h0, ins_q[11:0]};
    assign is_alu   = (op == OP_PLUS) || (op == OP_MINUS);
    assign is_print = (op == OP_PRINT);

    // Stage register; held only while a PRINT waits for FIFO space
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ins_q <= 16'h0000;
            val_q <= 16'h0000;
            ptr_q <= 16'h0000;
        end else if (!exec_stall) begin
            ins_q <= ins_in;
            val_q <= val_in;
            ptr_q <= ptr_in;
        end
    end

    always_comb begin
        res = val_q + imm;
        if (op == OP_MINUS) res = val_q - imm;
    end

    // Every valid, locked entry whose tag matches the pointer takes the result and unlocks
    always_comb begin
        rf_out = rf_in;
        if (is_alu) begin
            for (int i = 0; i < int'(NCORES); i++) begin
                if (rf_in[i*ENTRY_W + 34] && rf_in[i*ENTRY_W + 32] &&
                    (rf_in[i*ENTRY_W + 16 +: 16] == ptr_q)) begin
                    rf_out[i*ENTRY_W +: 16]  = res;
                    rf_out[i*ENTRY_W + 32]   = 1'b0;
                end
            end
        end
    end

    assign branch_en = (op == OP_BRZ) && (val_q == 16'h0000);
    assign branch_pc = imm;

    assign full        = (count_q == CNT_W'(PRINT_DEPTH));
    assign print_valid = (count_q != '0);
    assign print_data  = mem[rd_q];
    assign pop         = print_valid && print_ready;
    assign push        = is_print && (!full || pop);
    assign exec_stall  = is_print && full && !pop;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + PTR_W'(1);
            if (pop)  rd_q <= rd_q + PTR_W'(1);
            if (push && !pop)      count_q <= count_q + CNT_W'(1);
            else if (pop && !push) count_q <= count_q - CNT_W'(1);
        end
    end

    // Storage needs no reset: entries are only visible once counted
    always_ff @(posedge clk) begin
        if (push) mem[wr_q] <= val_q[7:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              core_done <= 1'b0;
        else if (op == OP_END)   core_done <= 1'b1;
    end

`ifdef EXEC_PRINT_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   print_cnt <= 16'h0000;
        else if (pop) print_cnt <= print_cnt + 16'h0001;
    end
`endif

endmodule
